window_watchdog_core: RTL
=========================

Name: window_watchdog_core

Overview:
- Windowed watchdog timer. Sits directly downstream of configuration_register.
- Consumes FWLEN, SWLEN, RST_LMT, WDSRVC and INIT, and produces FLSTAT plus the system reset request WDRST.
- Times a closed window followed by an open window and checks that service edges fall in the open window.
- Counts early and late faults, and locks into reset once the fault count reaches RST_LMT.

Parameters:
- PRESC, default 1: clock cycles per watchdog tick. Range 1..65535. Benches use 1.
- CNTW, default 8: width of the window and fault counters. Must be at least 8.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, synchronous, active-low.
- INIT  in  1  run enable from configuration_register. Level-sensitive.
- FWLEN  in  8  closed (first) window length, in ticks.
- SWLEN  in  8  open (second) window length, in ticks.
- RST_LMT  in  8  number of faults that triggers WDRST.
- WDSRVC  in  1  service request. Only a rising edge counts.
- FLSTAT  out  3  sticky fault status: [0] early service, [1] late (timeout), [2] limit reached.
- WDRST  out  1  system reset request. Level; held until RST.
- WINOPEN  out  1  high while in the OPEN state.
- FLTCNT  out  8  running fault count, saturating at 255.

Behaviour:
- Reset (RST=0 at a rising CLK edge):
  - state=IDLE; FLSTAT=0, WDRST=0, WINOPEN=0, FLTCNT=0.
  - Prescaler, window counter and WDSRVC edge register all cleared.
- Service edge detection:
  - svc = WDSRVC & ~wdsrvc_q, where wdsrvc_q is WDSRVC registered each cycle.
  - A WDSRVC held high counts once.
- Tick generation:
  - The prescaler counts 0..PRESC-1 and asserts tick at PRESC-1.
  - It runs only in CLOSED and OPEN, and clears on every window entry.
- Window latching: FWLEN and SWLEN are latched on entry to each window. Changes mid-window take effect at the next window.
- IDLE:
  - On INIT=1, go to CLOSED.
  - If the latched FWLEN is 0, the closed window is skipped and the core enters OPEN directly.
- CLOSED:
  - Window counter increments on tick.
  - On the tick where the count reaches FWLEN-1, go to OPEN, so CLOSED lasts FWLEN*PRESC cycles.
  - svc in any CLOSED cycle, including the final one: early fault. Set FLSTAT[0], increment FLTCNT, restart CLOSED.
- OPEN:
  - WINOPEN=1. SWLEN=0 is treated as 1.
  - svc: valid service. Restart CLOSED; no status change.
  - No svc by the tick where the count reaches SWLEN-1: late fault. Set FLSTAT[1], increment FLTCNT, restart CLOSED.
  - svc and timeout in the same cycle: service wins, no fault.
- Fault limit:
  - Evaluated on the incremented count, with limit = max(RST_LMT,1).
  - When FLTCNT_next >= limit, set FLSTAT[2], set WDRST=1 and go to LOCKED. The early/late bit for that fault is also set.
- LOCKED:
  - Terminal state; ignores svc and INIT. Only RST exits it.
  - WINOPEN=0, counters frozen.
- Latency: all outputs are registered. Status, WDRST and FLTCNT update at the clock edge that samples the triggering svc or timeout, and are visible the following cycle.
- INIT deasserted in CLOSED or OPEN:
  - Go to IDLE at the next edge; prescaler and window counter cleared.
  - FLSTAT and FLTCNT are retained.
  - Re-asserting INIT starts a fresh CLOSED window.
- FLSTAT bits are sticky; only RST clears them.
- FLTCNT saturates at 255.

Test Plan:
1. PRESC=1, FWLEN=4, SWLEN=4, RST_LMT=3, INIT=1. Pulse WDSRVC in cycle 6 after entering CLOSED (inside OPEN) -> no fault, FLSTAT=000, FLTCNT=0, CLOSED restarts; WINOPEN high for cycles 4..6 only.
2. Same config; pulse WDSRVC at cycle 2 of CLOSED -> FLSTAT=001, FLTCNT=1 the next cycle, CLOSED restarts, WINOPEN stays 0.
3. Same config, no service -> WINOPEN high for cycles 4..7; FLSTAT=010, FLTCNT=1 after cycle 7; then 2 more timeouts -> FLTCNT=3, FLSTAT=110, WDRST=1. WDSRVC and INIT toggling afterwards -> no change until RST=0, which clears all outputs.
4. Boundaries:
   - FWLEN=0 -> WINOPEN the cycle after INIT.
   - SWLEN=0 -> one-cycle open window.
   - RST_LMT=0 -> first early fault gives FLSTAT=101, WDRST=1.
   - WDSRVC rising exactly on the last OPEN cycle -> valid service, no fault.
5. Reconfiguration and INIT: change FWLEN 4->8 mid-CLOSED -> current window still 4 cycles, next window 8. Drop INIT mid-OPEN with FLTCNT=1 -> IDLE, WINOPEN=0, FLTCNT stays 1.
6. Integration: pattern_comparator and configuration_register drive this core, with WDSRVC held high for 5 cycles in OPEN -> counted as a single service, no early fault on the following CLOSED window.

Source files
------------

// File: rtl/window_watchdog_core.sv
// Windowed watchdog core. A closed window is followed by an open window and a
// service edge must land inside the open window. Early and late faults are
// counted, and once the count reaches the limit the core locks into a reset
// request that only RST can clear.
module window_watchdog_core #(
   parameter int PRESC = 1,
   parameter int CNTW  = 8
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       INIT,
   input  logic [7:0] FWLEN,
   input  logic [7:0] SWLEN,
   input  logic [7:0] RST_LMT,
   input  logic       WDSRVC,
   output logic [2:0] FLSTAT,
   output logic       WDRST,
   output logic       WINOPEN,
   output logic [7:0] FLTCNT
);

   typedef enum logic [1:0] {IDLE, CLOSED, OPEN, LOCKED} state_t;

   localparam logic [15:0] PLAST = 16'(PRESC - 1);

   state_t          state, state_n;
   logic [15:0]     pcnt, pcnt_n;
   logic [CNTW-1:0] wcnt, wcnt_n;
   logic [CNTW-1:0] wlast, wlast_n;
   logic [7:0]      fcnt, fcnt_n;
   logic [7:0]      fcnt_inc;
   logic [7:0]      limit;
   logic [2:0]      flstat, flstat_n;
   logic            wdrst, wdrst_n;
   logic            wdsrvc_q;
   logic            svc;
   logic            tick;
   logic            enter_closed;
   logic            enter_open;
   logic            fault_early;
   logic            fault_late;

   assign svc      = WDSRVC & ~wdsrvc_q;
   assign tick     = (pcnt == PLAST);
   assign limit    = (RST_LMT == 8'd0) ? 8'd1 : RST_LMT;
   assign fcnt_inc = (fcnt == 8'hFF) ? fcnt : fcnt + 8'd1;

   // Next-state, window timing and fault bookkeeping for the watchdog FSM
   always_comb begin
      state_n      = state;
      pcnt_n       = pcnt;
      wcnt_n       = wcnt;
      wlast_n      = wlast;
      fcnt_n       = fcnt;
      flstat_n     = flstat;
      wdrst_n      = wdrst;
      enter_closed = 1'b0;
      enter_open   = 1'b0;
      fault_early  = 1'b0;
      fault_late   = 1'b0;

      case (state)
         IDLE: begin
            if (INIT) begin
               enter_closed = 1'b1;
            end
         end
         CLOSED: begin
            if (!INIT) begin
               state_n = IDLE;
               pcnt_n  = '0;
               wcnt_n  = '0;
            end else if (svc) begin
               fault_early  = 1'b1;
               enter_closed = 1'b1;
            end else begin
               pcnt_n = tick ? '0 : pcnt + 16'd1;
               if (tick) begin
                  if (wcnt == wlast) begin
                     enter_open = 1'b1;
                  end else begin
                     wcnt_n = wcnt + 1'b1;
                  end
               end
            end
         end
         OPEN: begin
            if (!INIT) begin
               state_n = IDLE;
               pcnt_n  = '0;
               wcnt_n  = '0;
            end else if (svc) begin
               enter_closed = 1'b1;
            end else begin
               pcnt_n = tick ? '0 : pcnt + 16'd1;
               if (tick) begin
                  if (wcnt == wlast) begin
                     fault_late   = 1'b1;
                     enter_closed = 1'b1;
                  end else begin
                     wcnt_n = wcnt + 1'b1;
                  end
               end
            end
         end
         default: begin
         end
      endcase

      if (enter_closed) begin
         if (FWLEN == 8'd0) begin
            enter_open = 1'b1;
         end else begin
            state_n = CLOSED;
            pcnt_n  = '0;
            wcnt_n  = '0;
            wlast_n = CNTW'(FWLEN) - 1'b1;
         end
      end

      if (enter_open) begin
         state_n = OPEN;
         pcnt_n  = '0;
         wcnt_n  = '0;
         wlast_n = (SWLEN == 8'd0) ? '0 : CNTW'(SWLEN) - 1'b1;
      end

      if (fault_early || fault_late) begin
         fcnt_n   = fcnt_inc;
         flstat_n = flstat | {1'b0, fault_late, fault_early};
         if (fcnt_inc >= limit) begin
            flstat_n[2] = 1'b1;
            wdrst_n     = 1'b1;
            state_n     = LOCKED;
            pcnt_n      = pcnt;
            wcnt_n      = wcnt;
         end
      end
   end

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state    <= IDLE;
         pcnt     <= '0;
         wcnt     <= '0;
         wlast    <= '0;
         fcnt     <= '0;
         flstat   <= '0;
         wdrst    <= 1'b0;
         wdsrvc_q <= 1'b0;
      end else begin
         state    <= state_n;
         pcnt     <= pcnt_n;
         wcnt     <= wcnt_n;
         wlast    <= wlast_n;
         fcnt     <= fcnt_n;
         flstat   <= flstat_n;
         wdrst    <= wdrst_n;
         wdsrvc_q <= WDSRVC;
      end
   end

   assign FLSTAT  = flstat;
   assign WDRST   = wdrst;
   assign WINOPEN = (state == OPEN);
   assign FLTCNT  = fcnt;

endmodule
